// File: rtl/data_ram_arbiter_if.sv
// Requester-side bundle for one data_ram_arbiter port: request/command in,
// completion pulse with read data and error back.
interface data_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  wena;
    logic [1:0]            size;
    logic                  z;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  ack;
    logic [31:0]           rdata;
    logic                  err;

    modport master (
        output req, wena, size, z, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, wena, size, z, addr, wdata,
        output ack, rdata, err
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// Round-robin two-port arbiter that turns each grant into a single data_ram
// access cycle (IDLE -> ACCESS -> RESP) and returns rdata/err to the requester.
module data_ram_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    data_ram_arbiter_if.slave     m0,
    data_ram_arbiter_if.slave     m1,
    output logic                  busy,
    output logic                  ram_ena,
    output logic                  wena,
    output logic                  w,
    output logic                  h,
    output logic                  b,
    output logic                  z,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           data_in,
    input  logic [31:0]           data_out,
    input  logic                  AddressError
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    logic                  last_grant_r;
    logic                  cmd_port_r;
    logic                  cmd_wena_r;
    logic                  cmd_rsvd_r;

    logic                  grant_valid_s;
    logic                  grant_port_s;
    logic                  sel_wena_s;
    logic [1:0]            sel_size_s;
    logic                  sel_z_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [31:0]           sel_wdata_s;

    logic                  cap_err_s;
    logic [31:0]           cap_rdata_s;

    logic                  ram_ena_s, wena_s, w_s, h_s, b_s, z_s, busy_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [31:0]           data_in_s;
    logic                  ack0_s, ack1_s, err0_s, err1_s;
    logic [31:0]           rdata0_s, rdata1_s;

    logic                  ram_ena_r, wena_r, w_r, h_r, b_r, z_r, busy_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           data_in_r;
    logic                  ack0_r, ack1_r, err0_r, err1_r;
    logic [31:0]           rdata0_r, rdata1_r;

    // Size code to {w,h,b} one-hot; the reserved code selects no lane.
    function automatic logic [2:0] size_onehot(input logic [1:0] size);
        logic [2:0] lanes;
        case (size)
            2'b00:   lanes = 3'b100;
            2'b01:   lanes = 3'b010;
            2'b10:   lanes = 3'b001;
            default: lanes = 3'b000;
        endcase
        return lanes;
    endfunction

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Arbitration and next-state: a tie goes to the port that did not win last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
        if (m0.req && m1.req) begin
            grant_valid_s = 1'b1;
            grant_port_s  = ~last_grant_r;
        end else if (m0.req) begin
            grant_valid_s = 1'b1;
            grant_port_s  = 1'b0;
        end else if (m1.req) begin
            grant_valid_s = 1'b1;
            grant_port_s  = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_port_s  = 1'b0;
        end

        sel_wena_s  = grant_port_s ? m1.wena  : m0.wena;
        sel_size_s  = grant_port_s ? m1.size  : m0.size;
        sel_z_s     = grant_port_s ? m1.z     : m0.z;
        sel_addr_s  = grant_port_s ? m1.addr  : m0.addr;
        sel_wdata_s = grant_port_s ? m1.wdata : m0.wdata;

        case (state_r)
            IDLE:    state_s = grant_valid_s ? ACCESS : IDLE;
            ACCESS:  state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of every registered output; RAM pins are loaded on the grant
    // edge so they are valid for exactly the ACCESS cycle.
    always_comb begin
        ram_ena_s   = 1'b0;
        wena_s      = 1'b0;
        w_s         = 1'b0;
        h_s         = 1'b0;
        b_s         = 1'b0;
        z_s         = 1'b0;
        addr_s      = {ADDR_WIDTH{1'b0}};
        data_in_s   = 32'd0;
        ack0_s      = 1'b0;
        ack1_s      = 1'b0;
        err0_s      = 1'b0;
        err1_s      = 1'b0;
        rdata0_s    = rdata0_r;
        rdata1_s    = rdata1_r;
        busy_s      = (state_s != IDLE);
        cap_err_s   = cmd_rsvd_r ? 1'b1 : AddressError;
        cap_rdata_s = cmd_rsvd_r ? 32'd0 : data_out;

        if ((state_r == IDLE) && grant_valid_s && (sel_size_s != 2'b11)) begin
            ram_ena_s       = 1'b1;
            wena_s          = sel_wena_s;
            {w_s, h_s, b_s} = size_onehot(sel_size_s);
            z_s             = sel_z_s;
            addr_s          = sel_addr_s;
            data_in_s       = sel_wdata_s;
        end else begin
            ram_ena_s = 1'b0;
        end

        if (state_r == ACCESS) begin
            ack0_s = ~cmd_port_r;
            ack1_s = cmd_port_r;
            err0_s = ~cmd_port_r & cap_err_s;
            err1_s = cmd_port_r & cap_err_s;
            if (!cmd_wena_r) begin
                rdata0_s = cmd_port_r ? rdata0_r : cap_rdata_s;
                rdata1_s = cmd_port_r ? cap_rdata_s : rdata1_r;
            end else begin
                rdata0_s = rdata0_r;
                rdata1_s = rdata1_r;
            end
        end else begin
            ack0_s = 1'b0;
            ack1_s = 1'b0;
        end
    end

    // Command and round-robin pointer, captured on the grant edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            cmd_port_r   <= 1'b0;
            cmd_wena_r   <= 1'b0;
            cmd_rsvd_r   <= 1'b0;
        end else if ((state_r == IDLE) && grant_valid_s) begin
            last_grant_r <= grant_port_s;
            cmd_port_r   <= grant_port_s;
            cmd_wena_r   <= sel_wena_s;
            cmd_rsvd_r   <= (sel_size_s == 2'b11);
        end else begin
            last_grant_r <= last_grant_r;
            cmd_port_r   <= cmd_port_r;
            cmd_wena_r   <= cmd_wena_r;
            cmd_rsvd_r   <= cmd_rsvd_r;
        end
    end

    // Output registers; reset clears RAM controls and acks at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ena_r <= 1'b0;
            wena_r    <= 1'b0;
            w_r       <= 1'b0;
            h_r       <= 1'b0;
            b_r       <= 1'b0;
            z_r       <= 1'b0;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            data_in_r <= 32'd0;
            busy_r    <= 1'b0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            err0_r    <= 1'b0;
            err1_r    <= 1'b0;
            rdata0_r  <= 32'd0;
            rdata1_r  <= 32'd0;
        end else begin
            ram_ena_r <= ram_ena_s;
            wena_r    <= wena_s;
            w_r       <= w_s;
            h_r       <= h_s;
            b_r       <= b_s;
            z_r       <= z_s;
            addr_r    <= addr_s;
            data_in_r <= data_in_s;
            busy_r    <= busy_s;
            ack0_r    <= ack0_s;
            ack1_r    <= ack1_s;
            err0_r    <= err0_s;
            err1_r    <= err1_s;
            rdata0_r  <= rdata0_s;
            rdata1_r  <= rdata1_s;
        end
    end

    assign ram_ena  = ram_ena_r;
    assign wena     = wena_r;
    assign w        = w_r;
    assign h        = h_r;
    assign b        = b_r;
    assign z        = z_r;
    assign addr     = addr_r;
    assign data_in  = data_in_r;
    assign busy     = busy_r;
    assign m0.ack   = ack0_r;
    assign m1.ack   = ack1_r;
    assign m0.err   = err0_r;
    assign m1.err   = err1_r;
    assign m0.rdata = rdata0_r;
    assign m1.rdata = rdata1_r;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: a little-endian 64-byte data_ram model behind the
// DUT, and a byte-array reference model that predicts every response.
module tb_data_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        busy, ram_ena, wena, w, h, b, z;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        AddressError;

    data_ram_arbiter_if #(.ADDR_WIDTH(32)) m0_bus ();
    data_ram_arbiter_if #(.ADDR_WIDTH(32)) m1_bus ();

    data_ram_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .busy         (busy),
        .ram_ena      (ram_ena),
        .wena         (wena),
        .w            (w),
        .h            (h),
        .b            (b),
        .z            (z),
        .addr         (addr),
        .data_in      (data_in),
        .data_out     (data_out),
        .AddressError (AddressError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] prev_rd [2];

    // ---------------- data_ram model ----------------
    logic [31:0] ram_words [0:15];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_val;
    logic [31:0] rw;
    logic [15:0] hw;
    logic [7:0]  bt;

    always_comb begin
        AddressError = 1'b0;
        data_out     = 32'd0;
        rw           = ram_words[addr[5:2]];
        hw           = 16'd0;
        bt           = 8'd0;
        if (ram_ena) begin
            if (addr >= 32'd64 || (w && addr[1:0] != 2'd0) || (h && addr[0])) begin
                AddressError = 1'b1;
            end else if (w) begin
                data_out = rw;
            end else if (h) begin
                hw       = addr[1] ? rw[31:16] : rw[15:0];
                data_out = z ? {16'd0, hw} : {{16{hw[15]}}, hw};
            end else if (b) begin
                bt       = rw[{addr[1:0], 3'b000} +: 8];
                data_out = z ? {24'd0, bt} : {{24{bt[7]}}, bt};
            end
        end
    end

    always @(posedge clk) begin
        if (pl_en) begin
            ram_words[pl_idx] <= pl_val;
        end else if (ram_ena && wena && !AddressError) begin
            if (w) ram_words[addr[5:2]] <= data_in;
            else if (h && addr[1]) ram_words[addr[5:2]][31:16] <= data_in[15:0];
            else if (h) ram_words[addr[5:2]][15:0] <= data_in[15:0];
            else if (b) ram_words[addr[5:2]][{addr[1:0], 3'b000} +: 8] <= data_in[7:0];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:63];

    function automatic int ref_len(input logic [1:0] s);
        return (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b11) return 1'b1;
        if (a >= 64) return 1'b1;
        return (a % ref_len(s)) != 0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s, input bit zx);
        int n;
        longint v;
        if (ref_err(a, s)) return 32'd0;
        n = ref_len(s);
        v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[a + k]) << (8 * k));
        if (!zx && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        if (!ref_err(a, s)) begin
            for (int k = 0; k < ref_len(s); k++) ref_mem[a + k] = 8'(wd >> (8 * k));
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive_port(input bit port, input bit rq, input bit we, input logic [1:0] sz,
                              input bit zx, input logic [31:0] a, input logic [31:0] wd);
        if (port) begin
            m1_bus.req = rq; m1_bus.wena = we; m1_bus.size = sz;
            m1_bus.z = zx; m1_bus.addr = a; m1_bus.wdata = wd;
        end else begin
            m0_bus.req = rq; m0_bus.wena = we; m0_bus.size = sz;
            m0_bus.z = zx; m0_bus.addr = a; m0_bus.wdata = wd;
        end
    endtask

    // Issues one request and observes the bus until ack or a 20-cycle bound.
    task automatic run_txn(input bit port, input bit we, input logic [1:0] sz, input bit zx,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int ena_n, output int dirty_n, output logic [31:0] seen_addr,
                           output bit other_ack);
        @(negedge clk);
        drive_port(port, 1'b1, we, sz, zx, a, wd);
        lat = 0; ena_n = 0; dirty_n = 0; seen_addr = 32'd0; other_ack = 1'b0; rd = 32'd0; er = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (ram_ena) begin
                ena_n++;
                seen_addr = addr;
            end else if (wena || w || h || b || z || addr != 32'd0 || data_in != 32'd0) begin
                dirty_n++;
            end
            if (port ? m0_bus.ack : m1_bus.ack) other_ack = 1'b1;
            if (port ? m1_bus.ack : m0_bus.ack) begin
                rd = port ? m1_bus.rdata : m0_bus.rdata;
                er = port ? m1_bus.err : m0_bus.err;
                break;
            end
        end
        drive_port(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic preload();
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v = $urandom;
            pl_en = 1'b1; pl_idx = 4'(i); pl_val = v;
            for (int k = 0; k < 4; k++) ref_mem[4 * i + k] = 8'(v >> (8 * k));
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, ram_ena, wena, w, h, b, z, m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err} !== 11'd0
            || addr !== 32'd0 || data_in !== 32'd0 || m0_bus.rdata !== 32'd0 || m1_bus.rdata !== 32'd0)
            begin n_fail++; $display("FAIL reset_outputs: outputs not all zero in reset"); end
        rst = 1'b0;
        prev_rd[0] = 32'd0; prev_rd[1] = 32'd0;
        @(negedge clk);
        n_checks++;
        if ({busy, ram_ena, m0_bus.ack, m1_bus.ack} !== 4'd0)
            begin n_fail++; $display("FAIL reset_idle: busy/ena/ack=%b required 0000", {busy, ram_ena, m0_bus.ack, m1_bus.ack}); end
    endtask

    task automatic test_word_write_read();
        int lat, ena_n, dirty_n; logic [31:0] rd, sa; logic er; bit oa;
        run_txn(1'b0, 1'b1, 2'b00, 1'b0, 32'd0, 32'hffff0000, lat, rd, er, ena_n, dirty_n, sa, oa);
        ref_write(32'd0, 2'b00, 32'hffff0000);
        n_checks++;
        if (lat !== 2 || er !== 1'b0 || ena_n !== 1 || rd !== prev_rd[0])
            begin n_fail++; $display("FAIL word_write: lat=%0d err=%b ena=%0d rdata=%h required 2 0 1 %h", lat, er, ena_n, rd, prev_rd[0]); end
        run_txn(1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 32'd0, lat, rd, er, ena_n, dirty_n, sa, oa);
        prev_rd[0] = 32'hffff0000;
        n_checks++;
        if (lat !== 2 || er !== 1'b0 || ena_n !== 1 || rd !== 32'hffff0000)
            begin n_fail++; $display("FAIL word_read: lat=%0d err=%b ena=%0d rdata=%h required 2 0 1 ffff0000", lat, er, ena_n, rd); end
    endtask

    task automatic test_half_byte();
        int lat, ena_n, dirty_n; logic [31:0] rd, sa; logic er; bit oa;
        run_txn(1'b1, 1'b1, 2'b01, 1'b0, 32'd4, 32'h0000ffff, lat, rd, er, ena_n, dirty_n, sa, oa);
        ref_write(32'd4, 2'b01, 32'h0000ffff);
        n_checks++;
        if (lat !== 2 || er !== 1'b0 || sa !== 32'd4 || oa !== 1'b0)
            begin n_fail++; $display("FAIL half_write: lat=%0d err=%b addr=%h other_ack=%b required 2 0 4 0", lat, er, sa, oa); end
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, lat, rd, er, ena_n, dirty_n, sa, oa);
        n_checks++;
        if (rd !== 32'hffffffff || er !== 1'b0)
            begin n_fail++; $display("FAIL byte_sext: rdata=%h err=%b required ffffffff 0", rd, er); end
        run_txn(1'b1, 1'b0, 2'b10, 1'b1, 32'd4, 32'd0, lat, rd, er, ena_n, dirty_n, sa, oa);
        prev_rd[1] = 32'h000000ff;
        n_checks++;
        if (rd !== 32'h000000ff || er !== 1'b0)
            begin n_fail++; $display("FAIL byte_zext: rdata=%h err=%b required 000000ff 0", rd, er); end
    endtask

    task automatic test_errors();
        int lat, ena_n, dirty_n; logic [31:0] rd, sa; logic er; bit oa;
        run_txn(1'b0, 1'b0, 2'b11, 1'b0, 32'd8, 32'd0, lat, rd, er, ena_n, dirty_n, sa, oa);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0 || ena_n !== 0 || lat !== 2 || dirty_n !== 0)
            begin n_fail++; $display("FAIL reserved_size: err=%b rdata=%h ena=%0d lat=%0d dirty=%0d required 1 0 0 2 0", er, rd, ena_n, lat, dirty_n); end
        run_txn(1'b0, 1'b0, 2'b00, 1'b0, 32'd2, 32'd0, lat, rd, er, ena_n, dirty_n, sa, oa);
        prev_rd[0] = ref_read(32'd2, 2'b00, 1'b0);
        n_checks++;
        if (er !== 1'b1 || ena_n !== 1 || lat !== 2 || rd !== prev_rd[0])
            begin n_fail++; $display("FAIL misaligned_word: err=%b ena=%0d lat=%0d rdata=%h required 1 1 2 %h", er, ena_n, lat, rd, prev_rd[0]); end
    endtask

    task automatic test_contention();
        logic [31:0] a0, a1;
        int got, cyc, last_cyc, n0, n1, both;
        int order [4];
        int gap [4];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev_rd[0] = 32'd0; prev_rd[1] = 32'd0;
        a0 = 32'd8; a1 = 32'd12; n0 = 0; n1 = 0;
        got = 0; cyc = 0; last_cyc = 0; both = 0;
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, a0, 32'd0);
        drive_port(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, a1, 32'd0);
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (m0_bus.ack && m1_bus.ack) both++;
            if (m0_bus.ack && got < 4) begin
                n_checks++;
                if (m0_bus.rdata !== ref_read(a0, 2'b00, 1'b0))
                    begin n_fail++; $display("FAIL contention_rd0: rdata=%h required %h", m0_bus.rdata, ref_read(a0, 2'b00, 1'b0)); end
                prev_rd[0] = ref_read(a0, 2'b00, 1'b0);
                order[got] = 0; gap[got] = cyc - last_cyc; last_cyc = cyc; got++; n0++;
                a0 = a0 + 32'd16;
                drive_port(1'b0, n0 < 2, 1'b0, 2'b00, 1'b0, a0, 32'd0);
            end
            if (m1_bus.ack && got < 4) begin
                n_checks++;
                if (m1_bus.rdata !== ref_read(a1, 2'b00, 1'b0))
                    begin n_fail++; $display("FAIL contention_rd1: rdata=%h required %h", m1_bus.rdata, ref_read(a1, 2'b00, 1'b0)); end
                prev_rd[1] = ref_read(a1, 2'b00, 1'b0);
                order[got] = 1; gap[got] = cyc - last_cyc; last_cyc = cyc; got++; n1++;
                a1 = a1 + 32'd16;
                drive_port(1'b1, n1 < 2, 1'b0, 2'b00, 1'b0, a1, 32'd0);
            end
        end
        drive_port(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        drive_port(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        n_checks++;
        if (got !== 4 || both !== 0)
            begin n_fail++; $display("FAIL contention_count: acks=%0d both_high=%0d required 4 0", got, both); end
        for (int i = 0; i < got; i++) begin
            n_checks++;
            if (order[i] !== (i % 2) || gap[i] !== (i == 0 ? 2 : 3))
                begin n_fail++; $display("FAIL contention_order: slot %0d port=%0d gap=%0d required %0d %0d", i, order[i], gap[i], i % 2, (i == 0 ? 2 : 3)); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] wd;
        int lat, ena_n;
        bit acked;
        wd = $urandom;
        @(negedge clk);
        drive_port(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'd32, wd);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, ram_ena, wena, w, m0_bus.ack, m1_bus.ack} !== 6'd0 || addr !== 32'd0 || data_in !== 32'd0)
            begin n_fail++; $display("FAIL reset_mid_access: busy/ena/wena/w/acks=%b addr=%h required all 0", {busy, ram_ena, wena, w, m0_bus.ack, m1_bus.ack}, addr); end
        @(negedge clk);
        rst = 1'b0;
        prev_rd[0] = 32'd0; prev_rd[1] = 32'd0;
        lat = 0; ena_n = 0; acked = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (ram_ena) ena_n++;
            if (m1_bus.ack) begin acked = 1'b1; break; end
        end
        drive_port(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        ref_write(32'd32, 2'b00, wd);
        n_checks++;
        if (!acked || lat !== 2 || ena_n !== 1 || m1_bus.rdata !== 32'd0 || m1_bus.err !== 1'b0)
            begin n_fail++; $display("FAIL reset_rearb: acked=%b lat=%0d ena=%0d rdata=%h required 1 2 1 0", acked, lat, ena_n, m1_bus.rdata); end
    endtask

    task automatic test_random();
        int lat, ena_n, dirty_n; logic [31:0] rd, sa, a, wd, exp_rd; logic er; bit oa, port, we, zx; logic [1:0] sz;
        for (int i = 0; i < 40; i++) begin
            port = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            zx   = 1'($urandom_range(0, 1));
            a    = $urandom_range(0, 71);
            wd   = $urandom;
            run_txn(port, we, sz, zx, a, wd, lat, rd, er, ena_n, dirty_n, sa, oa);
            exp_rd = we ? prev_rd[port] : ref_read(a, sz, zx);
            if (we) ref_write(a, sz, wd);
            else prev_rd[port] = exp_rd;
            n_checks++;
            if (lat !== 2 || er !== ref_err(a, sz) || rd !== exp_rd || ena_n !== (sz == 2'b11 ? 0 : 1)
                || dirty_n !== 0 || oa !== 1'b0 || (ena_n == 1 && sa !== a))
                begin n_fail++; $display("FAIL random_%0d: port=%0d we=%0d sz=%0d a=%0d lat=%0d err=%b rdata=%h ena=%0d addr=%h required lat 2 err %b rdata %h", i, port, we, sz, a, lat, er, rd, ena_n, sa, ref_err(a, sz), exp_rd); end
        end
    endtask

    initial begin
        rst = 1'b1;
        pl_en = 1'b0; pl_idx = 4'd0; pl_val = 32'd0;
        drive_port(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        drive_port(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        preload();
        test_reset();
        test_word_write_read();
        test_half_byte();
        test_errors();
        test_contention();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-port arbiter and access sequencer for `data_ram`. It shares the single data RAM between port 0 (CPU MEM stage) and port 1 (debug/DMA loader), and grants them round-robin. It converts each granted request into one RAM access cycle and returns read data and the RAM's `AddressError` to the issuing port. It sits between the pipeline/debug logic and the `data_ram` instance.

## Interface
- `ADDR_WIDTH`, default 32: width of request and RAM address.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req` / `m1_req`  in  1  request. Held high with a stable command until ack.
- `m0_wena` / `m1_wena`  in  1  1 = write, 0 = read.
- `m0_size` / `m1_size`  in  2  00 word, 01 half, 10 byte, 11 reserved.
- `m0_z` / `m1_z`  in  1  read extension: 1 = zero-extend, 0 = sign-extend. Passed to the RAM `z` input.
- `m0_addr` / `m1_addr`  in  ADDR_WIDTH  byte address.
- `m0_wdata` / `m1_wdata`  in  32  write data, right-aligned.
- `m0_ack` / `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata` / `m1_rdata`  out  32  read result. Valid while ack is high, held until the next ack on that port.
- `m0_err` / `m1_err`  out  1  error flag, qualified by ack.
- `busy`  out  1  high in ACCESS and RESP.
- `ram_ena`, `wena`, `w`, `h`, `b`, `z`  out  1 each  RAM controls.
- `addr`  out  ADDR_WIDTH  RAM address.
- `data_in`  out  32  RAM write data.
- `data_out`  in  32  RAM read data. Combinational, valid while `ram_ena` is high.
- `AddressError`  in  1  RAM alignment/range error. Combinational, valid while `ram_ena` is high.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one `mN_req` is high, grant it.
  - If both are high, grant the port that is not `last_grant`.
  - On a grant: register the command (wena, size, z, addr, wdata, port id), update `last_grant`, go to ACCESS.
- **ACCESS** (exactly one cycle)
  - Drive the RAM from the registered command: `ram_ena`=1, `wena`, and one-hot `w`/`h`/`b` from size.
  - Capture `data_out` and `AddressError` into response registers at the cycle-end edge. The RAM performs a write on that same edge.
  - Size 11: `ram_ena`=0, no RAM access, captured err=1, captured rdata=0.
  - Go to RESP.
- **RESP** (exactly one cycle)
  - Assert `mN_ack` for the granted port only.
  - `mN_err` = captured error. `mN_rdata` is updated for reads only; writes leave the previous rdata.
  - Go to IDLE.
- Requests are ignored in ACCESS and RESP.
- A requester may drop `req` or present a new command at the edge where it sees ack.
- When `ram_ena`=0, all RAM outputs (`wena`, `w`, `h`, `b`, `z`, `addr`, `data_in`) are 0.
- The arbiter never modifies `addr` or `data_in`. Alignment checking and lane steering belong to `data_ram`.

## Timing
- Reset values:
  - Every output is 0.
  - `last_grant`=1, so port 0 wins the first tie.
  - Response registers are 0.
  - FSM is in IDLE.
- Latency: `req` high in IDLE cycle N → RAM access in cycle N+1 → ack in cycle N+2. Throughput is one access per 3 cycles.
- Under continuous contention the grants strictly alternate 0,1,0,1. Neither port waits more than one transaction.
- A request arriving in ACCESS or RESP is first considered in the following IDLE cycle.
- Reset asserted mid-transaction, in any state:
  - RAM controls and acks drop to 0 immediately.
  - The in-flight access is abandoned; no ack is issued.
  - After release, a still-held `req` is re-arbitrated from IDLE.
- A write whose `AddressError` is 1 still reports err=1. Whether the RAM suppressed the write is the RAM's responsibility.

## Test plan
- **Port 0 word write then read back.** Write addr=0, wdata=32'hffff0000, size=00. Then read addr=0, z=1. Expect:
  - ack at N+2 for each transaction, err=0.
  - `m0_rdata`=32'hffff0000.
  - `ram_ena` high for exactly one cycle per transaction.
- **Port 1 half and byte accesses.** Half write addr=4, wdata=32'h0000ffff. Then byte read addr=4, z=0 gives rdata=32'hffffffff. Byte read addr=4, z=1 gives 32'h000000ff.
- **Contention.** Hold both reqs high, reading different addresses, for 4 transactions. Expect grant order 0,1,0,1, ack period 3 cycles, and `m0_ack` and `m1_ack` never high together.
- **Errors.**
  - size=11 on port 0: err=1, rdata=0, `ram_ena` stays 0.
  - Word read at addr=2 where the RAM raises `AddressError`: ack with err=1.
- **Reset mid-ACCESS.** Port 1 write is in flight. Pulse `rst` asynchronously mid-cycle. Expect:
  - All outputs 0 at once, no ack.
  - With `m1_req` still high after release, a fresh ack arrives 2 cycles after the first IDLE.
